// File: rtl/kbd_fifo.sv
// Keyboard key FIFO for the KBD/KBDCR register pair at 0xD010..0xD011.
// Optional: define KBD_FIFO_UPPERCASE_EN to fold a..z to A..Z on entry.
module kbd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     sys_clock,
    input  logic                     reset_n,
    input  logic                     cpu_clken,
    input  logic                     cs,
    input  logic                     address,
    input  logic                     we,
    input  logic                     key_valid,
    input  logic [6:0]               key_data,
    output logic [7:0]               dout,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [6:0]    last_q;
    logic [6:0]    head;
    logic [6:0]    key_in;
    logic          rd;
    logic          pop;
    logic          push;
    logic          empty;
    logic          full;

    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);
    assign rd    = cs & cpu_clken & ~we;
    assign pop   = rd & ~address & ~empty;
    assign push  = key_valid & (~full | pop);

`ifdef KBD_FIFO_UPPERCASE_EN
    // Fold lowercase ASCII to uppercase before it is stored
    always_comb begin
        key_in = key_data;
        if (key_data >= 7'h61 && key_data <= 7'h7A)
            key_in = key_data - 7'h20;
    end
`else
    assign key_in = key_data;
`endif

    // Oldest entry, or the last value read out once the queue drains
    always_comb begin
        head = last_q;
        if (!empty)
            head = mem[rd_ptr];
    end

    // CPU read mux: KBD has bit 7 tied high, KBDCR reports data ready
    always_comb begin
        dout = {1'b1, head};
        if (address)
            dout = {~empty, 7'b0};
    end

    // Storage array; the slot under wr_ptr is written on every push
    always_ff @(posedge sys_clock) begin
        if (push)
            mem[wr_ptr] <= key_in;
    end

    // Pointers, occupancy, retired-head latch and sticky overflow
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            last_q   <= 7'h00;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
            if (key_valid & full & ~pop)
                overflow <= 1'b1;
            else if (rd & address)
                overflow <= 1'b0;
        end
    end

endmodule

// File: doc/kbd_fifo.md
KBD_FIFO -- requirements
Module: kbd_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of key entries stored; legal values are powers of two, 2..64.
REQ-002 SHALL have port sys_clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port cpu_clken, input, 1 bit: CPU clock enable; qualifies every CPU-side access.
REQ-005 SHALL have port cs, input, 1 bit: keyboard chip select for the 0xD010..0xD011 window.
REQ-006 SHALL have port address, input, 1 bit: CPU A0; 0 selects KBD, 1 selects KBDCR.
REQ-007 SHALL have port we, input, 1 bit: CPU write enable; CPU writes are ignored.
REQ-008 SHALL have port key_valid, input, 1 bit: single-cycle strobe from the PS/2 decoder.
REQ-009 SHALL have port key_data, input, 7 bits: ASCII code, sampled when key_valid=1.
REQ-010 SHALL have port dout, output, 8 bits: read data to the CPU data-in mux.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag, set when a key was dropped.
REQ-012 SHALL have port level, output, log2(DEPTH)+1 bits: current occupancy.

Function
REQ-013 SHALL define read strobe rd = cs & cpu_clken & ~we.
REQ-014 SHALL define pop = rd & (address==0) & ~empty.
REQ-015 SHALL define push = key_valid & (~full | pop).
REQ-016 SHALL drive dout combinationally: address 0 gives {1'b1, head[6:0]}; address 1 gives {~empty, 7'b0}.
REQ-017 SHALL drive head as the oldest stored entry; when empty, head SHALL hold the last popped value (0x00 after reset).
REQ-018 SHALL make a pushed key visible on KBDCR bit 7 and on head in the cycle after the push edge (latency 1).
REQ-019 SHALL, on push and pop in the same cycle, store the new key, retire the old head, and leave level unchanged; this SHALL also apply when full.
REQ-020 SHALL, on key_valid while full without a pop, drop the key, leave contents unchanged, and set overflow.
REQ-021 SHALL clear overflow on rd with address 1; a simultaneous set SHALL take priority over the clear.
REQ-022 SHALL ignore a pop when empty: no pointer move, no underflow, and head unchanged.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; full = (level==DEPTH), empty = (level==0).
REQ-024 SHALL ignore any access with cpu_clken=0, so one CPU cycle pops at most one entry.
REQ-025 SHALL treat a write to either address as no effect on state.

Reset
REQ-026 SHALL, when reset_n=0, asynchronously clear pointers, set level=0, overflow=0 and head=0x00, giving dout=0x80 at address 0 and dout=0x00 at address 1.
REQ-027 SHALL, on reset asserted mid-operation, discard all stored keys; key_valid during reset SHALL be lost.
REQ-028 SHALL resume normal operation on the first rising edge after reset_n deasserts.

Configuration
REQ-029 SHALL, with macro KBD_FIFO_UPPERCASE_EN defined, convert key_data 0x61..0x7A to 0x41..0x5A before storage and pass other codes unchanged.
REQ-030 SHALL, without KBD_FIFO_UPPERCASE_EN, store key_data unmodified.

Verification
REQ-031 SHALL cover reset: reset_n low, then high -> level=0, overflow=0, dout=0x80 at address 0 and dout=0x00 at address 1.
REQ-032 SHALL cover ordering: push 0x41, 0x42, 0x43, then three KBD reads -> dout 0xC1, 0xC2, 0xC3; KBDCR then reads 0x00.
REQ-033 SHALL cover overflow: DEPTH=8, push 9 keys -> level=8, overflow=1; KBDCR read returns 0x80 and then overflow=0; the ninth key is absent.
REQ-034 SHALL cover full with simultaneous push and pop: full FIFO, key_valid with KBD read in the same cycle -> level stays 8, overflow stays 0, new key is last out.
REQ-035 SHALL cover empty pop: KBD read when empty -> level 0, dout=0x80|last popped value, no pointer move.
REQ-036 SHALL cover the macro: with KBD_FIFO_UPPERCASE_EN, push 0x61 -> KBD reads 0xC1; without it -> 0xE1.
